// File: rtl/lcd_view_scheduler_pkg.sv
// Shared types and helpers for the LCD view scheduler: view encoding,
// one-hot enable mapping and the scheduler FSM state enum.
package lcd_view_pkg;

    typedef enum logic [1:0] {
        VIEW_CLOCK     = 2'd0,
        VIEW_SET       = 2'd1,
        VIEW_STOPWATCH = 2'd2,
        VIEW_ALARM     = 2'd3
    } view_t;

    typedef enum logic [2:0] {
        ST_SHOW      = 3'd0,
        ST_PEND      = 3'd1,
        ST_RING_PEND = 3'd2,
        ST_RING      = 3'd3,
        ST_RESTORE   = 3'd4
    } sched_state_t;

    // CLOCK lands on the MSB so the enable reads left to right in view order.
    function automatic logic [3:0] onehot(input view_t v);
        return 4'b1000 >> v;
    endfunction

    function automatic view_t next_view(input view_t v);
        return view_t'(v + 2'd1);
    endfunction

endpackage

// File: rtl/lcd_view_scheduler_if.sv
// Control/status bundle between buttons/timekeeping, the view scheduler
// and the text-LCD driver.
interface lcd_view_scheduler_if;

    logic       mode_btn;
    logic       ack_btn;
    logic       alarm_hit;
    logic       tick_1hz;
    logic       frame_done;
    logic [3:0] enable;
    logic       ring;
    logic       busy;

    // master: the surrounding logic that produces events and consumes view selects
    modport master (
        output mode_btn,
        output ack_btn,
        output alarm_hit,
        output tick_1hz,
        output frame_done,
        input  enable,
        input  ring,
        input  busy
    );

    // slave: the scheduler itself
    modport slave (
        input  mode_btn,
        input  ack_btn,
        input  alarm_hit,
        input  tick_1hz,
        input  frame_done,
        output enable,
        output ring,
        output busy
    );

endinterface

// File: rtl/lcd_view_scheduler_frame_switch_timer.sv
// Frame-synchronised switch point: fires on frame_done, or after a watchdog
// interval if the LCD driver never reports a completed frame.
module frame_switch_timer #(
    parameter int FRAME_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic arm,
    input  logic frame_done,
    output logic switch_now
);

    localparam int WD_W = $clog2(FRAME_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(FRAME_TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt_reg;

    assign switch_now = arm && (frame_done || (wd_cnt_reg == WD_LAST));

    // Dropping arm for one cycle is how the owner restarts the interval.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt_reg <= '0;
        end else if (!arm || switch_now) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_view_scheduler.sv
// Chooses the view shown by the text-LCD driver, applying every change on a
// frame boundary and letting an alarm preempt and later restore the view.
module lcd_view_scheduler
    import lcd_view_pkg::*;
#(
    parameter int          RING_SECS     = 30,
    parameter int          FRAME_TIMEOUT = 1024,
    parameter logic [1:0]  RESET_VIEW    = 2'd0
) (
    input  logic                  clk,
    input  logic                  resetn,
    lcd_view_scheduler_if.slave   bus
);

    localparam view_t      RST_VIEW  = view_t'(RESET_VIEW);
    localparam logic [7:0] RING_LAST = 8'(RING_SECS);

    sched_state_t state_reg;
    view_t        cur_view_reg;
    view_t        pend_view_reg;
    view_t        saved_view_reg;
    logic [7:0]   sec_cnt_reg;
    logic [3:0]   enable_reg;
    logic         ring_reg;
    logic         busy_reg;

    logic         arm;
    logic         switch_now;
    logic         pend_abort;
    logic         dismiss;

    // An alarm in PEND re-enters a switching state, so the watchdog must restart.
    assign pend_abort = (state_reg == ST_PEND) && bus.alarm_hit;
    assign arm        = ((state_reg == ST_PEND) || (state_reg == ST_RING_PEND) ||
                         (state_reg == ST_RESTORE)) && !pend_abort;
    assign dismiss    = bus.ack_btn || bus.mode_btn || (sec_cnt_reg == RING_LAST);

    frame_switch_timer #(
        .FRAME_TIMEOUT (FRAME_TIMEOUT)
    ) u_switch_timer (
        .clk        (clk),
        .resetn     (resetn),
        .arm        (arm),
        .frame_done (bus.frame_done),
        .switch_now (switch_now)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_SHOW;
            cur_view_reg   <= RST_VIEW;
            pend_view_reg  <= RST_VIEW;
            saved_view_reg <= RST_VIEW;
            sec_cnt_reg    <= '0;
            enable_reg     <= onehot(RST_VIEW);
            ring_reg       <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_SHOW: begin
                    if (bus.alarm_hit) begin
                        saved_view_reg <= cur_view_reg;
                        pend_view_reg  <= VIEW_ALARM;
                        ring_reg       <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_RING_PEND;
                    end else if (bus.mode_btn) begin
                        pend_view_reg  <= next_view(cur_view_reg);
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_PEND;
                    end
                end

                ST_PEND: begin
                    if (bus.alarm_hit) begin
                        saved_view_reg <= cur_view_reg;
                        pend_view_reg  <= VIEW_ALARM;
                        ring_reg       <= 1'b1;
                        state_reg      <= ST_RING_PEND;
                    end else if (switch_now) begin
                        // A same-cycle mode press loses to the frame boundary.
                        cur_view_reg   <= pend_view_reg;
                        enable_reg     <= onehot(pend_view_reg);
                        busy_reg       <= 1'b0;
                        state_reg      <= ST_SHOW;
                    end else if (bus.mode_btn) begin
                        pend_view_reg  <= next_view(pend_view_reg);
                    end
                end

                ST_RING_PEND: begin
                    if (switch_now) begin
                        cur_view_reg   <= pend_view_reg;
                        enable_reg     <= onehot(pend_view_reg);
                        busy_reg       <= 1'b0;
                        sec_cnt_reg    <= '0;
                        state_reg      <= ST_RING;
                    end
                end

                ST_RING: begin
                    if (dismiss) begin
                        ring_reg       <= 1'b0;
                        pend_view_reg  <= saved_view_reg;
                        busy_reg       <= 1'b1;
                        sec_cnt_reg    <= '0;
                        state_reg      <= ST_RESTORE;
                    end else if (bus.tick_1hz) begin
                        sec_cnt_reg    <= sec_cnt_reg + 8'd1;
                    end
                end

                ST_RESTORE: begin
                    if (switch_now) begin
                        cur_view_reg   <= pend_view_reg;
                        enable_reg     <= onehot(pend_view_reg);
                        busy_reg       <= 1'b0;
                        state_reg      <= ST_SHOW;
                    end
                end

                default: begin
                    state_reg   <= ST_SHOW;
                    sec_cnt_reg <= '0;
                    busy_reg    <= 1'b0;
                    ring_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.enable = enable_reg;
    assign bus.ring   = ring_reg;
    assign bus.busy   = busy_reg;

endmodule
